fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode field position and fetch FSM states
package cpu_pkg;
  localparam int INS_W   = 32;
  localparam int ADDR_W  = 64;
  localparam int OPC_W   = 11;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam int CNT_W   = 3;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear, full/empty flags and occupancy count
module fetch_fifo #(
  parameter int W = 8,
  parameter int D = 2,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_full  = r_cnt == CW'(D);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  // pointers and count; clear drops every entry at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= inc(r_wr);
      if (w_pop) r_rd <= inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  // storage needs no reset: the count gates every read
  always_ff @(posedge clk)
    if (w_push && !i_clr) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with in-order tags, decode buffer and redirect flush
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INS_W-1:0]  imem_rsp_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INS_W-1:0]  ins_word,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [OPC_W-1:0]  opcode,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int BW = ADDR_W + INS_W;
  fetch_state_t      r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_out, r_drop, w_out_nx;
  logic              w_req_fire, w_ins_fire, w_redir, w_push;
  logic [ADDR_W-1:0] w_tag_pc;
  logic              w_tag_full, w_tag_empty, w_buf_full, w_buf_empty;
  logic [CW-1:0]     w_tag_cnt, w_buf_cnt;
  logic [BW-1:0]     w_head;
  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_ins_fire = ins_valid & ins_ready;
  assign w_redir    = redirect_valid & (r_state != IDLE);
  assign w_out_nx   = r_out + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
  assign w_push     = imem_rsp_valid & (r_state == RUN) & ~redirect_valid;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  // next state: a redirect with nothing left in flight skips FLUSH
  always_comb
    w_state_nx = (r_state == IDLE) ? RUN :
                 w_redir ? ((w_out_nx == '0) ? RUN : FLUSH) :
                 (r_state == FLUSH && imem_rsp_valid && r_drop == CNT_W'(1)) ? RUN : r_state;
  // request only while every possible response still has a buffer slot
  always_comb
    imem_req_valid = (r_state == RUN) && ((4'(r_out) + 4'(w_buf_cnt)) < 4'(BUF_DEPTH));
  // pc, in-flight count and stale-response count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= w_out_nx;
      if (redirect_valid) r_pc <= redirect_pc & ~64'h3;
      else if (w_req_fire) r_pc <= r_pc + 64'd4;
      if (w_redir) r_drop <= w_out_nx;
      else if (r_state == FLUSH && imem_rsp_valid) r_drop <= r_drop - 1'b1;
    end
  fetch_fifo #(.W(ADDR_W), .D(BUF_DEPTH)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_push  (w_req_fire),
    .i_pop   (imem_rsp_valid),
    .i_din   (r_pc),
    .o_dout  (w_tag_pc),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_cnt)
  );
  fetch_fifo #(.W(BW), .D(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_redir),
    .i_push  (w_push),
    .i_pop   (w_ins_fire),
    .i_din   ({w_tag_pc, imem_rsp_data}),
    .o_dout  (w_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_count (w_buf_cnt)
  );
  assign imem_req_addr = r_pc;
  assign ins_valid     = ~w_buf_empty;
  assign ins_word      = ins_valid ? w_head[INS_W-1:0] : '0;
  assign ins_pc        = ins_valid ? w_head[BW-1:INS_W] : '0;
  assign opcode        = ins_valid ? w_head[OPC_MSB:OPC_LSB] : '0;
  a_rsp_orphan: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> r_out != '0);
  a_tag_sync: assert property (@(posedge clk) disable iff (rst)
    (32'(w_tag_cnt) == 32'(r_out)) && (w_tag_empty == (r_out == '0)) && !(w_tag_full && w_req_fire));
  a_buf_room: assert property (@(posedge clk) disable iff (rst) !(w_buf_full && w_push && !w_ins_fire));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked cycle by cycle against a queue-based model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        ins_valid, ins_ready = 1'b0;
  logic [31:0] ins_word;
  logic [63:0] ins_pc;
  logic [10:0] opcode;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word), .ins_pc(ins_pc), .opcode(opcode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  int checks = 0, errors = 0;
  int cyc = 0, n0 = 0;
  int p_ready = 100, p_rsp = 100, p_insr = 100, lat_max = 0;
  logic [63:0] m_pc = 64'h0;
  logic [95:0] m_buf [$];
  logic [63:0] m_tags [$];
  logic [63:0] mq_addr [$];
  int          mq_due [$];
  bit          m_run = 0, m_flush = 0;
  int          m_drop = 0;
  logic [63:0] fired [$];
  logic [63:0] d_pc [$];
  logic [10:0] d_opc [$];
  logic [63:0] exp_pc;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] memw(input logic [63:0] a);
    return (a == 64'h0) ? 32'hF840_0000 : (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234;
  endfunction
  function automatic bit exp_rv();
    return m_run && !m_flush && (m_tags.size() + m_buf.size() < DEPTH);
  endfunction
  task automatic compare();
    bit v;
    logic [95:0] h;
    v = m_buf.size() > 0;
    h = v ? m_buf[0] : '0;
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv()));
    chk("req_addr", imem_req_addr, m_pc);
    chk("ins_valid", 64'(ins_valid), 64'(v));
    if (v) begin
      chk("ins_pc", ins_pc, h[95:32]);
      chk("ins_word", 64'(ins_word), 64'(h[31:0]));
      chk("opcode", 64'(opcode), 64'(h[31:21]));
    end else chk("opcode_idle", 64'(opcode), 64'h0);
  endtask
  task automatic step(input bit redir = 1'b0, input logic [63:0] rpc = 64'h0);
    bit fire, rsp, hs;
    logic [31:0] d;
    logic [63:0] tag;
    compare();
    imem_req_ready = $urandom_range(99) < p_ready;
    rsp = mq_addr.size() > 0 && mq_due[0] <= cyc && $urandom_range(99) < p_rsp;
    d = rsp ? memw(mq_addr[0]) : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data = d;
    ins_ready = $urandom_range(99) < p_insr;
    redirect_valid = redir;
    redirect_pc = rpc;
    #1;
    if (imem_req_valid && imem_req_ready) fired.push_back(imem_req_addr);
    if (ins_valid && ins_ready) begin
      d_pc.push_back(ins_pc);
      d_opc.push_back(opcode);
    end
    fire = exp_rv() && imem_req_ready;
    hs = m_buf.size() > 0 && ins_ready;
    if (hs) void'(m_buf.pop_front());
    if (rsp) begin
      tag = m_tags.pop_front();
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      if (!redir) begin
        if (m_flush) m_drop--;
        else m_buf.push_back({tag, d});
      end
    end
    if (fire) begin
      m_tags.push_back(m_pc);
      mq_addr.push_back(m_pc);
      mq_due.push_back(cyc + 1 + int'($urandom_range(lat_max)));
      m_pc += 64'd4;
    end
    if (m_flush && m_drop == 0) m_flush = 0;
    if (redir) begin
      m_pc = {rpc[63:2], 2'b00};
      if (m_run) begin
        m_buf.delete();
        m_drop = m_tags.size();
        m_flush = m_drop != 0;
      end
    end
    m_run = 1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask
  task automatic do_reset();
    #2;
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    ins_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_ins_valid", 64'(ins_valid), 64'h0);
    chk("rst_ins_word", 64'(ins_word), 64'h0);
    chk("rst_ins_pc", ins_pc, 64'h0);
    chk("rst_opcode", 64'(opcode), 64'h0);
    m_buf.delete();
    m_tags.delete();
    mq_addr.delete();
    mq_due.delete();
    m_pc = 64'h0;
    m_run = 0;
    m_flush = 0;
    m_drop = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("first_req0", fired[0], 64'h0);
    chk("first_req1", fired[1], 64'h4);
    chk("first_req2", fired[2], 64'h8);
    chk("first_pc0", d_pc[0], 64'h0);
    chk("first_pc1", d_pc[1], 64'h4);
    chk("first_pc2", d_pc[2], 64'h8);
    chk("first_opc", 64'(d_opc[0]), 64'h7C2);
    p_insr = 0;
    n0 = fired.size();
    for (int i = 0; i < 10; i++) step();
    chk("stall_fires", 64'(fired.size() - n0 <= DEPTH), 64'h1);
    p_insr = 100;
    for (int i = 0; i < 6; i++) step();
    p_rsp = 0;
    for (int i = 0; i < 20 && m_tags.size() < 2; i++) step();
    chk("two_outstanding", 64'(m_tags.size()), 64'h2);
    n0 = d_pc.size();
    step(1'b1, 64'h100);
    p_rsp = 100;
    for (int i = 0; i < 30 && d_pc.size() <= n0; i++) step();
    chk("flush_first_pc", (d_pc.size() > n0) ? d_pc[n0] : 64'hDEAD, 64'h100);
    p_insr = 60;
    for (int i = 0; i < 200 && !(m_buf.size() > 0 && mq_addr.size() > 0 && mq_due[0] <= cyc); i++) step();
    chk("coincide_ready", 64'(m_buf.size() > 0 && mq_addr.size() > 0 && mq_due[0] <= cyc), 64'h1);
    exp_pc = (m_buf.size() > 0) ? m_buf[0][95:32] : 64'h0;
    p_insr = 100;
    n0 = d_pc.size();
    step(1'b1, 64'h200);
    chk("coincide_once", 64'(d_pc.size()), 64'(n0 + 1));
    chk("coincide_pc", (d_pc.size() > n0) ? d_pc[n0] : 64'hDEAD, exp_pc);
    chk("coincide_nvalid", 64'(ins_valid), 64'h0);
    for (int i = 0; i < 30 && d_pc.size() <= n0 + 1; i++) step();
    chk("coincide_next_pc", (d_pc.size() > n0 + 1) ? d_pc[n0 + 1] : 64'hDEAD, 64'h200);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    n0 = fired.size();
    for (int i = 0; i < 50 && fired.size() < n0 + 2; i++) step();
    chk("wrap_req0", (fired.size() > n0) ? fired[n0] : 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req1", (fired.size() > n0 + 1) ? fired[n0 + 1] : 64'hDEAD, 64'h0);
    lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      p_ready = $urandom_range(20, 100);
      p_rsp = $urandom_range(20, 100);
      p_insr = $urandom_range(10, 100);
      if ($urandom_range(99) < 4) step(1'b1, {$urandom, $urandom});
      else step();
    end
    p_ready = 100;
    p_insr = 100;
    lat_max = 0;
    p_rsp = 0;
    for (int i = 0; i < 30 && m_tags.size() < 2; i++) step();
    chk("rst_two_outstanding", 64'(m_tags.size()), 64'h2);
    do_reset();
    p_rsp = 100;
    n0 = fired.size();
    for (int i = 0; i < 10 && fired.size() <= n0; i++) step();
    chk("rst_first_req", (fired.size() > n0) ? fired[n0] : 64'hDEAD, 64'h0);
    for (int i = 0; i < 300; i++) begin
      p_ready = $urandom_range(30, 100);
      p_rsp = $urandom_range(30, 100);
      p_insr = $urandom_range(30, 100);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
